seq_pattern_tx: RTL



---
 rtl/seq_tx_pkg.sv | 14 +
 rtl/piso_shift.sv | 44 ++++
 rtl/seq_pattern_tx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding
// and the default level driven on the line while not transmitting.
package seq_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP_S = 2'd2,
      DONE  = 2'd3
   } tx_state_e;

   localparam logic IDLE_BIT_DEF = 1'b0;

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, serial-out register (MSB first). Keeps a private copy of the
// loaded pattern so each repetition can be reloaded without the input bus.
module piso_shift #(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             reload_i,
   input  logic             shift_i,
   input  logic [PAT_W-1:0] pat_i,
   output logic             msb_next_o
);

   logic [PAT_W-1:0] copy_q, copy_d;
   logic [PAT_W-1:0] sh_q, sh_d;

   always_comb begin
      copy_d = copy_q;
      sh_d   = sh_q;
      if (load_i) begin
         copy_d = pat_i;
         sh_d   = pat_i;
      end else if (reload_i) begin
         sh_d = copy_q;
      end else if (shift_i) begin
         sh_d = {sh_q[PAT_W-2:0], 1'b0};
      end
   end

   // Look-ahead bit lets the parent register the serial output in step with its state.
   assign msb_next_o = sh_d[PAT_W-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         copy_q <= '0;
         sh_q   <= '0;
      end else begin
         copy_q <= copy_d;
         sh_q   <= sh_d;
      end
   end

endmodule

// File: rtl/seq_pattern_tx.sv
// Bit-serial pattern transmitter: sends a captured pattern MSB first, repeated
// repeat_n times with GAP idle cycles between repetitions, then pulses done.
module seq_pattern_tx
   import seq_tx_pkg::*;
#(
   parameter int   PAT_W    = 4,
   parameter int   CNT_W    = 8,
   parameter int   GAP      = 0,
   parameter logic IDLE_BIT = IDLE_BIT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   output logic             busy,
   output logic             signal,
   output logic             sig_valid,
   output logic             done
);

   localparam int BC_W = $clog2(PAT_W);
   localparam int GC_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [BC_W-1:0] BIT_LAST = BC_W'(PAT_W - 1);
   localparam logic [GC_W-1:0] GAP_LAST = GC_W'((GAP > 0) ? GAP - 1 : 0);

   tx_state_e        state_q, state_d;
   logic [BC_W-1:0]  bit_q, bit_d;
   logic [CNT_W-1:0] rep_q, rep_d;
   logic [GC_W-1:0]  gap_q, gap_d;
   logic             busy_q, busy_d;
   logic             signal_q, signal_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;

   logic load, reload, shift_en, sh_next;

   piso_shift #(
      .PAT_W(PAT_W)
   ) u_piso (
      .clk       (clk),
      .rst_n     (rst),
      .load_i    (load),
      .reload_i  (reload),
      .shift_i   (shift_en),
      .pat_i     (pattern),
      .msb_next_o(sh_next)
   );

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      rep_d    = rep_q;
      gap_d    = gap_q;
      load     = 1'b0;
      reload   = 1'b0;
      shift_en = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (repeat_n != '0) begin
                  state_d = SHIFT;
                  load    = 1'b1;
                  rep_d   = repeat_n;
                  bit_d   = '0;
               end else begin
                  state_d = DONE;
               end
            end
         end
         SHIFT: begin
            if (bit_q == BIT_LAST) begin
               bit_d = '0;
               // rep_q counts repetitions still owed, including the one just finished.
               if (rep_q > CNT_W'(1)) begin
                  rep_d = rep_q - CNT_W'(1);
                  if (GAP > 0) begin
                     state_d = GAP_S;
                     gap_d   = '0;
                  end else begin
                     reload = 1'b1;
                  end
               end else begin
                  rep_d   = '0;
                  state_d = DONE;
               end
            end else begin
               bit_d    = bit_q + BC_W'(1);
               shift_en = 1'b1;
            end
         end
         GAP_S: begin
            if (gap_q == GAP_LAST) begin
               state_d = SHIFT;
               reload  = 1'b1;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + GC_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d   = (state_d != IDLE);
      valid_d  = (state_d == SHIFT);
      done_d   = (state_d == DONE);
      signal_d = valid_d ? sh_next : IDLE_BIT;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         bit_q    <= '0;
         rep_q    <= '0;
         gap_q    <= '0;
         busy_q   <= 1'b0;
         signal_q <= IDLE_BIT;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bit_q    <= bit_d;
         rep_q    <= rep_d;
         gap_q    <= gap_d;
         busy_q   <= busy_d;
         signal_q <= signal_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
      end
   end

   assign busy      = busy_q;
   assign signal    = signal_q;
   assign sig_valid = valid_q;
   assign done      = done_q;

endmodule
